// File: rtl/i2c_sram_pkg.sv
// Shared FSM state encodings and I2C acknowledge levels for the I2C-to-SRAM burst bridge.
package i2c_sram_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        DEV_ADDR = 4'd1,
        DEV_ACK  = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_ACK  = 4'd4,
        WR_BYTE  = 4'd5,
        WR_ACK   = 4'd6,
        RD_BYTE  = 4'd7,
        RD_ACK   = 4'd8
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_sram_mem.sv
// Word storage: one synchronous write port, one registered read port, no reset.
module i2c_sram_mem #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/i2c_sram_burst.sv
// I2C slave exposing a word-organised SRAM with auto-incrementing burst reads and writes.
module i2c_sram_burst
    import i2c_sram_pkg::*;
#(
    parameter int DATA_BYTES = 2,
    parameter int ADDR_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [6:0] my_addr,
    output logic [6:0] rcvd_device_address,
    output logic       rcvd_mode,
    output logic [3:0] state,
    output logic       wr_done,
    output logic       busy
);

    localparam int         WIDTH    = 8 * DATA_BYTES;
    localparam logic [1:0] LAST_IDX = 2'(DATA_BYTES - 1);

    state_t            cur_state, state_next;
    logic              scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
    logic              scl_rise, scl_fall, start, stop, byte_done;
    logic [3:0]        bit_cnt;
    logic [7:0]        shreg, tx_byte;
    logic [6:0]        addr_lat;
    logic [ADDR_W-1:0] ptr;
    logic [1:0]        byte_idx, idx_next;
    logic [WIDTH-1:0]  word_buf, rdata;
    logic              sda_next, mem_we, tx_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d} <= '1;
        end else begin
            scl_s1 <= scl_in;  scl_s2 <= scl_s1;  scl_d <= scl_s2;
            sda_s1 <= sda_in;  sda_s2 <= sda_s1;  sda_d <= sda_s2;
        end
    end

    // START/STOP require SCL high in both samples, so a simultaneous SCL/SDA change is a data bit.
    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start     = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop      = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign byte_done = scl_fall && (bit_cnt == 4'd8);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_state <= IDLE;
        else       cur_state <= state_next;
    end

    always_comb begin
        state_next = cur_state;
        if (start) begin
            state_next = DEV_ADDR;
        end else if (stop) begin
            state_next = IDLE;
        end else if (scl_fall) begin
            case (cur_state)
                DEV_ADDR: if (bit_cnt == 4'd8) state_next = (shreg[7:1] == addr_lat) ? DEV_ACK : IDLE;
                DEV_ACK:  state_next = MEM_ADDR;
                MEM_ADDR: if (bit_cnt == 4'd8) state_next = MEM_ACK;
                MEM_ACK:  state_next = rcvd_mode ? RD_BYTE : WR_BYTE;
                WR_BYTE:  if (bit_cnt == 4'd8) state_next = WR_ACK;
                WR_ACK:   state_next = WR_BYTE;
                RD_BYTE:  if (bit_cnt == 4'd8) state_next = RD_ACK;
                RD_ACK:   state_next = (shreg[0] == ACK) ? RD_BYTE : IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        idx_next = byte_idx;
        case (cur_state)
            MEM_ACK:        idx_next = LAST_IDX;
            WR_ACK, RD_ACK: idx_next = (byte_idx == 2'd0) ? LAST_IDX : byte_idx - 2'd1;
            default:        idx_next = byte_idx;
        endcase
        // Entering RD_BYTE sends the MSB of the next byte; staying sends the next lower bit.
        tx_byte  = 8'(rdata >> (8 * idx_next));
        tx_bit   = (cur_state == RD_BYTE) ? tx_byte[3'd7 - bit_cnt[2:0]] : tx_byte[7];
        sda_next = sda_oe;
        if (start || stop) begin
            sda_next = 1'b0;
        end else if (scl_fall) begin
            case (state_next)
                DEV_ACK, MEM_ACK, WR_ACK: sda_next = 1'b1;
                RD_BYTE:                  sda_next = ~tx_bit;
                default:                  sda_next = 1'b0;
            endcase
        end
        mem_we = scl_fall && (cur_state == WR_ACK) && (byte_idx == 2'd0);
        busy   = (cur_state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sda_oe              <= 1'b0;
            wr_done             <= 1'b0;
            rcvd_device_address <= '0;
            rcvd_mode           <= 1'b0;
            ptr                 <= '0;
            bit_cnt             <= '0;
            shreg               <= '0;
            addr_lat            <= '0;
            byte_idx            <= '0;
            word_buf            <= '0;
        end else begin
            sda_oe  <= sda_next;
            wr_done <= mem_we;
            if (start) addr_lat <= my_addr;
            if (scl_rise) shreg <= {shreg[6:0], sda_s2};
            if (start || stop || (scl_fall && state_next != cur_state)) bit_cnt <= '0;
            else if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) byte_idx <= idx_next;
            if (byte_done && cur_state == DEV_ADDR) begin
                rcvd_device_address <= shreg[7:1];
                rcvd_mode           <= shreg[0];
            end
            if (byte_done && cur_state == MEM_ADDR) ptr <= ADDR_W'(shreg);
            if (byte_done && cur_state == WR_BYTE)
                word_buf <= (word_buf & ~(WIDTH'(8'hFF) << (8 * byte_idx))) | (WIDTH'(shreg) << (8 * byte_idx));
            // Read pointer advances on entering RD_ACK so the next word is ready a full SCL period early.
            if (mem_we || (byte_done && cur_state == RD_BYTE && byte_idx == 2'd0)) ptr <= ptr + ADDR_W'(1);
        end
    end

    i2c_sram_mem #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (ptr),
        .wdata (word_buf),
        .raddr (ptr),
        .rdata (rdata)
    );

    assign state = cur_state;

endmodule
